// File: rtl/fifo_mem_core_pkg.sv
// Shared FIFO parameter defaults, derived widths and types for the memory core.
package FIFO_param_pkg;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // Encoding matches {read_accepted, write_accepted}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_WR   = 2'b01,
    OP_RD   = 2'b10,
    OP_RW   = 2'b11
  } op_e;

endpackage

// File: rtl/fifo_mem_ram.sv
// DEPTH x WIDTH storage with synchronous write and a registered, resettable read-data port.
module fifo_mem_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read-first: a same-address write in this cycle is not visible until the next read.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_mem_core.sv
// Circular-buffer FIFO memory: pointers, occupancy count, error pulses and status flags.
// Define FIFO_MEM_ALMOST_FLAGS_EN to add the mem_afull / mem_aempty outputs.
module fifo_mem_core #(
  parameter int WIDTH = FIFO_param_pkg::WIDTH,
  parameter int DEPTH = FIFO_param_pkg::DEPTH
`ifdef FIFO_MEM_ALMOST_FLAGS_EN
  ,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
`endif
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             mem_wr_en,
  input  logic [WIDTH-1:0] fifo_wr_data,
  input  logic             mem_rd_en,
  output logic [WIDTH-1:0] fifo_rd_data,
  output logic             mem_wr_err,
  output logic             mem_rd_err,
  output logic             mem_full,
  output logic             mem_empty
`ifdef FIFO_MEM_ALMOST_FLAGS_EN
  ,
  output logic             mem_afull,
  output logic             mem_aempty
`endif
);

  import FIFO_param_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_err_q, wr_err_d;
  logic          rd_err_q, rd_err_d;
  logic          rd_accept, wr_accept;
  op_e           op;

  always_comb begin
    rd_accept = mem_rd_en && (count_q != '0);
    // A full FIFO can still take a write when a read frees a slot in the same cycle.
    wr_accept = mem_wr_en && ((count_q != CW'(DEPTH)) || rd_accept);
    op        = op_e'({rd_accept, wr_accept});

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wr_err_d = mem_wr_en && !wr_accept;
    rd_err_d = mem_rd_en && !rd_accept;

    if (wr_accept) begin
      wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (rd_accept) begin
      rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end

    case (op)
      OP_WR:   count_d = count_q + 1'b1;
      OP_RD:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wr_err_q <= wr_err_d;
      rd_err_q <= rd_err_d;
    end
  end

  fifo_mem_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (CLK),
    .srst_i  (RST),
    .we_i    (wr_accept && !RST),
    .waddr_i (wr_ptr_q),
    .wdata_i (fifo_wr_data),
    .re_i    (rd_accept && !RST),
    .raddr_i (rd_ptr_q),
    .rdata_o (fifo_rd_data)
  );

  assign mem_wr_err = wr_err_q;
  assign mem_rd_err = rd_err_q;
  assign mem_full   = (count_q == CW'(DEPTH));
  assign mem_empty  = (count_q == '0);

`ifdef FIFO_MEM_ALMOST_FLAGS_EN
  assign mem_afull  = (count_q >= CW'(AF_LEVEL));
  assign mem_aempty = (count_q <= CW'(AE_LEVEL));
`endif

endmodule

// File: tb/tb_fifo_mem_core.sv
// Scoreboard bench for fifo_mem_core at WIDTH=8, DEPTH=4; almost flags checked when FIFO_MEM_ALMOST_FLAGS_EN is set.
module tb_fifo_mem_core;

  localparam int W = 8;
  localparam int D = 4;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         mem_wr_en = 1'b0;
  logic         mem_rd_en = 1'b0;
  logic [W-1:0] fifo_wr_data = '0;
  logic [W-1:0] fifo_rd_data;
  logic         mem_wr_err;
  logic         mem_rd_err;
  logic         mem_full;
  logic         mem_empty;
`ifdef FIFO_MEM_ALMOST_FLAGS_EN
  logic         mem_afull;
  logic         mem_aempty;
`endif

  logic [W-1:0] model_q [$];
  logic [W-1:0] sb_q [$];
  logic [W-1:0] last_rd = '0;
  logic [W-1:0] exp_d;
  logic         exp_wr_err = 1'b0;
  logic         exp_rd_err = 1'b0;
  bit           rd_done = 1'b0;
  int           errors = 0;
  int           checks = 0;

  fifo_mem_core #(
    .WIDTH (W),
    .DEPTH (D)
`ifdef FIFO_MEM_ALMOST_FLAGS_EN
    ,
    .AF_LEVEL (3),
    .AE_LEVEL (2)
`endif
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .mem_wr_en    (mem_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .mem_rd_en    (mem_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .mem_wr_err   (mem_wr_err),
    .mem_rd_err   (mem_rd_err),
    .mem_full     (mem_full),
    .mem_empty    (mem_empty)
`ifdef FIFO_MEM_ALMOST_FLAGS_EN
    ,
    .mem_afull    (mem_afull),
    .mem_aempty   (mem_aempty)
`endif
  );

  always #5 CLK = ~CLK;

  // Drives one request cycle; the model decides acceptance and queues the expected read word.
  task automatic drive(input logic wr, input logic [W-1:0] d, input logic rd);
    bit rd_ok;
    bit wr_ok;
    mem_wr_en    = wr;
    fifo_wr_data = d;
    mem_rd_en    = rd;
    rd_ok = rd && (model_q.size() > 0);
    wr_ok = wr && ((model_q.size() < D) || rd_ok);
    exp_rd_err = rd && !rd_ok;
    exp_wr_err = wr && !wr_ok;
    rd_done    = rd_ok;
    if (rd_ok) sb_q.push_back(model_q.pop_front());
    if (wr_ok) model_q.push_back(d);
    @(posedge CLK);
    #1;
    mem_wr_en = 1'b0;
    mem_rd_en = 1'b0;
    $display("txn wr=%b data=%h rd=%b -> rd_data=%h wr_err=%b rd_err=%b full=%b empty=%b",
             wr, d, rd, fifo_rd_data, mem_wr_err, mem_rd_err, mem_full, mem_empty);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 8'h00, 1'b0);
      checks++; if (mem_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", mem_empty); end
      checks++; if (mem_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", mem_full); end
      checks++; if (fifo_rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h want 00", fifo_rd_data); end
      checks++; if ({mem_wr_err, mem_rd_err} !== 2'b00) begin errors++; $display("FAIL reset_errs: got %b want 00", {mem_wr_err, mem_rd_err}); end
`ifdef FIFO_MEM_ALMOST_FLAGS_EN
      checks++; if ({mem_afull, mem_aempty} !== 2'b01) begin errors++; $display("FAIL reset_almost: got %b want 01", {mem_afull, mem_aempty}); end
`endif
    end
  endtask

  task automatic test_fill_drain();
    logic [W-1:0] pat [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 8; i++) begin
      if (i < 4) drive(1'b1, pat[i], 1'b0);
      else       drive(1'b0, 8'h00, 1'b1);
      if (rd_done) begin
        exp_d = sb_q.pop_front();
        last_rd = exp_d;
        checks++; if (fifo_rd_data !== exp_d) begin errors++; $display("FAIL fill_rd_data: got %h want %h", fifo_rd_data, exp_d); end
      end
      checks++; if (mem_full !== (model_q.size() == D)) begin errors++; $display("FAIL fill_full: got %b want %b", mem_full, model_q.size() == D); end
      checks++; if (mem_empty !== (model_q.size() == 0)) begin errors++; $display("FAIL fill_empty: got %b want %b", mem_empty, model_q.size() == 0); end
      checks++; if ({mem_wr_err, mem_rd_err} !== 2'b00) begin errors++; $display("FAIL fill_errs: got %b want 00", {mem_wr_err, mem_rd_err}); end
`ifdef FIFO_MEM_ALMOST_FLAGS_EN
      checks++; if (mem_afull !== (model_q.size() >= 3)) begin errors++; $display("FAIL fill_afull: got %b want %b", mem_afull, model_q.size() >= 3); end
      checks++; if (mem_aempty !== (model_q.size() <= 2)) begin errors++; $display("FAIL fill_aempty: got %b want %b", mem_aempty, model_q.size() <= 2); end
`endif
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] pat [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) drive(1'b1, pat[i], 1'b0);
    drive(1'b1, 8'h55, 1'b0);
    checks++; if (mem_wr_err !== exp_wr_err || exp_wr_err !== 1'b1) begin errors++; $display("FAIL ovf_wr_err: got %b want 1", mem_wr_err); end
    checks++; if (mem_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", mem_full); end
    drive(1'b0, 8'h00, 1'b0);
    checks++; if (mem_wr_err !== 1'b0) begin errors++; $display("FAIL ovf_pulse_len: got %b want 0", mem_wr_err); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      exp_d = sb_q.pop_front();
      last_rd = exp_d;
      checks++; if (fifo_rd_data !== exp_d) begin errors++; $display("FAIL ovf_order: got %h want %h", fifo_rd_data, exp_d); end
    end
    checks++; if (mem_empty !== 1'b1) begin errors++; $display("FAIL ovf_empty: got %b want 1", mem_empty); end
  endtask

  task automatic test_underflow();
    drive(1'b0, 8'h00, 1'b1);
    checks++; if (mem_rd_err !== 1'b1) begin errors++; $display("FAIL udf_rd_err: got %b want 1", mem_rd_err); end
    checks++; if (fifo_rd_data !== last_rd) begin errors++; $display("FAIL udf_hold: got %h want %h", fifo_rd_data, last_rd); end
    drive(1'b1, 8'hA5, 1'b1);
    checks++; if (mem_rd_err !== exp_rd_err || exp_rd_err !== 1'b1) begin errors++; $display("FAIL udf_rw_rd_err: got %b want 1", mem_rd_err); end
    checks++; if (mem_wr_err !== 1'b0) begin errors++; $display("FAIL udf_rw_wr_err: got %b want 0", mem_wr_err); end
    checks++; if ({mem_full, mem_empty} !== 2'b00) begin errors++; $display("FAIL udf_rw_count1: got full/empty %b want 00", {mem_full, mem_empty}); end
    checks++; if (fifo_rd_data !== last_rd) begin errors++; $display("FAIL udf_no_bypass: got %h want %h", fifo_rd_data, last_rd); end
    drive(1'b0, 8'h00, 1'b1);
    exp_d = sb_q.pop_front();
    last_rd = exp_d;
    checks++; if (fifo_rd_data !== exp_d) begin errors++; $display("FAIL udf_read_a5: got %h want %h", fifo_rd_data, exp_d); end
    checks++; if (mem_rd_err !== 1'b0) begin errors++; $display("FAIL udf_rd_err_clear: got %b want 0", mem_rd_err); end
  endtask

  task automatic test_full_rw_wrap();
    for (int i = 0; i < 4; i++) drive(1'b1, 8'h61 + 8'(i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'h66 + 8'(i), 1'b1);
      exp_d = sb_q.pop_front();
      last_rd = exp_d;
      checks++; if (fifo_rd_data !== exp_d) begin errors++; $display("FAIL wrap_rd_data: got %h want %h", fifo_rd_data, exp_d); end
      checks++; if ({mem_wr_err, mem_rd_err} !== 2'b00) begin errors++; $display("FAIL wrap_errs: got %b want 00", {mem_wr_err, mem_rd_err}); end
      checks++; if (mem_full !== 1'b1) begin errors++; $display("FAIL wrap_full: got %b want 1", mem_full); end
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      exp_d = sb_q.pop_front();
      last_rd = exp_d;
      checks++; if (fifo_rd_data !== exp_d) begin errors++; $display("FAIL wrap_drain: got %h want %h", fifo_rd_data, exp_d); end
    end
    checks++; if (mem_empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b want 1", mem_empty); end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h71 + 8'(i), 1'b0);
`ifdef FIFO_MEM_ALMOST_FLAGS_EN
    checks++; if ({mem_afull, mem_aempty} !== 2'b10) begin errors++; $display("FAIL mid_almost_cnt3: got %b want 10", {mem_afull, mem_aempty}); end
`endif
    checks++; if ({mem_full, mem_empty} !== 2'b00) begin errors++; $display("FAIL mid_pre_flags: got %b want 00", {mem_full, mem_empty}); end
    RST = 1'b1; mem_wr_en = 1'b1; mem_rd_en = 1'b1; fifo_wr_data = 8'h99;
    @(posedge CLK);
    #1;
    RST = 1'b0; mem_wr_en = 1'b0; mem_rd_en = 1'b0;
    model_q.delete();
    sb_q.delete();
    last_rd = '0;
    $display("txn rst=1 wr=1 data=99 rd=1 -> rd_data=%h empty=%b", fifo_rd_data, mem_empty);
    checks++; if (mem_empty !== 1'b1) begin errors++; $display("FAIL mid_empty: got %b want 1", mem_empty); end
    checks++; if (fifo_rd_data !== 8'h00) begin errors++; $display("FAIL mid_rd_data: got %h want 00", fifo_rd_data); end
    checks++; if ({mem_wr_err, mem_rd_err} !== 2'b00) begin errors++; $display("FAIL mid_errs: got %b want 00", {mem_wr_err, mem_rd_err}); end
`ifdef FIFO_MEM_ALMOST_FLAGS_EN
    checks++; if ({mem_afull, mem_aempty} !== 2'b01) begin errors++; $display("FAIL mid_almost: got %b want 01", {mem_afull, mem_aempty}); end
`endif
    drive(1'b0, 8'h00, 1'b1);
    checks++; if (mem_rd_err !== 1'b1) begin errors++; $display("FAIL mid_no_write: got rd_err %b want 1", mem_rd_err); end
    drive(1'b1, 8'hB7, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    exp_d = sb_q.pop_front();
    checks++; if (fifo_rd_data !== exp_d) begin errors++; $display("FAIL mid_after_rst: got %h want %h", fifo_rd_data, exp_d); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_full_rw_wrap();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
